// File: rtl/snn_config_loader.sv
`default_nettype none
// ============================================================================
// snn_config_loader : byte-serial SNN weight/parameter loader, double-buffered
// Revision 1.0 - initial release
// ============================================================================
module snn_config_loader #(
  parameter int WEIGHT_BYTES = 27,
  parameter int PARAM_BYTES  = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      cfg_start,
  input  logic                      cfg_valid,
  input  logic [7:0]                cfg_data,
  output logic                      cfg_ready,
  output logic                      cfg_done,
  output logic                      net_enable,
  output logic [8*WEIGHT_BYTES-1:0] input_weights,
  output logic [8*PARAM_BYTES-1:0]  neuron_params
);

  localparam int         TOTAL = WEIGHT_BYTES + PARAM_BYTES;
  localparam logic [5:0] LAST  = 6'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state;
  logic [5:0]           cnt;
  logic [8*TOTAL-1:0]   shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      shadow        <= '0;
      input_weights <= '0;
      neuron_params <= '0;
      cfg_done      <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          // A start inside a frame restarts it; that cycle's data is dropped.
          if (cfg_start) begin
            cnt <= '0;
          end else if (cfg_valid) begin
            for (int i = 0; i < TOTAL; i++) begin
              if (cnt == 6'(i)) begin
                shadow[8*(TOTAL-1-i) +: 8] <= cfg_data;
              end
            end
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= COMMIT;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        COMMIT: begin
          // Only a completely written shadow is ever copied to the live buses.
          input_weights <= shadow[8*TOTAL-1 -: 8*WEIGHT_BYTES];
          neuron_params <= shadow[8*PARAM_BYTES-1:0];
          cfg_done      <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cfg_ready  = (state == LOAD);
  assign net_enable = enable && (state == IDLE) && !cfg_done;

endmodule
`default_nettype wire
